// File: rtl/factor_judge.sv
// Answer checker for the factorization game: latches three digits and a target,
// multiplies them with a shift-add datapath, and holds a wrong/correct verdict.
module factor_judge #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VALID,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic [9:0] TARGET,
    output logic [1:0] RESULT,
    output logic [9:0] PRODUCT,
    output logic [3:0] SCORE,
    output logic       BUSY
);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, CMP, SHOW} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state, state_nx;
    logic [1:0]        result_nx;
    logic              busy_nx;
    logic [3:0]        d1_r, d2_r, d3_r;
    logic [9:0]        target_r;
    logic [6:0]        part_r;
    logic [9:0]        acc_r;
    logic [1:0]        bit_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              correct;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd9);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

    // A zero or out-of-range digit is wrong even if the product happens to match.
    assign correct = (acc_r == target_r) && digit_ok(d1_r) && digit_ok(d2_r) && digit_ok(d3_r);

    always_comb begin
        state_nx  = state;
        result_nx = RESULT;
        busy_nx   = BUSY;
        case (state)
            IDLE:    if (VALID) state_nx = MUL1;
            MUL1:    if (bit_idx == 2'd3) state_nx = MUL2;
            MUL2:    if (bit_idx == 2'd3) state_nx = CMP;
            CMP:     state_nx = SHOW;
            SHOW:    if (hold_cnt == HOLD_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        case (state_nx)
            IDLE:    result_nx = 2'b00;
            SHOW:    if (state == CMP) result_nx = {correct, 1'b1};
            default: result_nx = 2'b10;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            RESULT   <= 2'b00;
            BUSY     <= 1'b0;
            PRODUCT  <= '0;
            SCORE    <= '0;
            d1_r     <= '0;
            d2_r     <= '0;
            d3_r     <= '0;
            target_r <= '0;
            part_r   <= '0;
            acc_r    <= '0;
            bit_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state  <= state_nx;
            RESULT <= result_nx;
            BUSY   <= busy_nx;
            case (state)
                IDLE: begin
                    if (VALID) begin
                        d1_r     <= D1;
                        d2_r     <= D2;
                        d3_r     <= D3;
                        target_r <= TARGET;
                        part_r   <= '0;
                        acc_r    <= '0;
                        bit_idx  <= '0;
                    end
                end
                MUL1: begin
                    if (d2_r[bit_idx]) part_r <= part_r + (7'(d1_r) << bit_idx);
                    bit_idx <= bit_idx + 2'd1;
                end
                MUL2: begin
                    if (d3_r[bit_idx]) acc_r <= acc_r + (10'(part_r) << bit_idx);
                    bit_idx <= bit_idx + 2'd1;
                end
                CMP: begin
                    PRODUCT  <= acc_r;
                    hold_cnt <= '0;
                    if (correct) SCORE <= sat_inc(SCORE);
                end
                SHOW:    hold_cnt <= hold_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_factor_judge.sv
// Bench for factor_judge with a short hold time; compares against an arithmetic model.
module tb_factor_judge;

    localparam int HOLD = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       VALID = 1'b0;
    logic [3:0] D1 = '0, D2 = '0, D3 = '0;
    logic [9:0] TARGET = '0;
    logic [1:0] RESULT;
    logic [9:0] PRODUCT;
    logic [3:0] SCORE;
    logic       BUSY;

    int checks = 0;
    int errors = 0;
    int exp_score = 0;

    factor_judge #(.HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
        .CLK(CLK), .RST(RST), .VALID(VALID), .D1(D1), .D2(D2), .D3(D3),
        .TARGET(TARGET), .RESULT(RESULT), .PRODUCT(PRODUCT), .SCORE(SCORE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit model_correct(input int a, input int b, input int c, input int t);
        return (a >= 1 && a <= 9) && (b >= 1 && b <= 9) && (c >= 1 && c <= 9) && (a * b * c == t);
    endfunction

    function automatic int model_score(input int s, input bit ok);
        return (ok && s < 9) ? s + 1 : s;
    endfunction

    // Called at a falling edge; returns at the falling edge just after the latch edge.
    task automatic pulse(input int a, input int b, input int c, input int t);
        D1 = 4'(a); D2 = 4'(b); D3 = 4'(c); TARGET = 10'(t);
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
    endtask

    task automatic to_verdict();
        repeat (9) @(negedge CLK);
    endtask

    task automatic to_idle();
        repeat (HOLD) @(negedge CLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if ({RESULT, PRODUCT, SCORE, BUSY} !== 17'd0) begin
            errors++;
            $display("FAIL reset_init got R=%b P=%0d S=%0d B=%b want all zero", RESULT, PRODUCT, SCORE, BUSY);
        end
        RST = 1'b1;
        @(negedge CLK);
        pulse(2, 2, 2, 8);
        to_verdict();
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({RESULT, PRODUCT, SCORE, BUSY} !== 17'd0) begin
            errors++;
            $display("FAIL reset_async got R=%b P=%0d S=%0d B=%b want all zero", RESULT, PRODUCT, SCORE, BUSY);
        end
        exp_score = 0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_correct();
        pulse(2, 3, 5, 30);
        for (int j = 0; j <= 8; j++) begin
            checks++;
            if (RESULT !== 2'b10 || BUSY !== 1'b1) begin
                errors++;
                $display("FAIL correct_busy_k%0d got R=%b B=%b want R=10 B=1", j, RESULT, BUSY);
            end
            if (j < 8) @(negedge CLK);
        end
        @(negedge CLK);
        exp_score = model_score(exp_score, 1'b1);
        checks++;
        if (RESULT !== 2'b11 || PRODUCT !== 10'd30 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL correct_verdict got R=%b P=%0d S=%0d want R=11 P=30 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        for (int j = 1; j < HOLD; j++) begin
            @(negedge CLK);
            checks++;
            if (RESULT !== 2'b11) begin
                errors++;
                $display("FAIL correct_hold%0d got R=%b want 11", j, RESULT);
            end
        end
        @(negedge CLK);
        checks++;
        if (RESULT !== 2'b00 || BUSY !== 1'b0 || PRODUCT !== 10'd30) begin
            errors++;
            $display("FAIL correct_idle got R=%b B=%b P=%0d want R=00 B=0 P=30", RESULT, BUSY, PRODUCT);
        end
    endtask

    task automatic test_max();
        pulse(9, 9, 9, 729);
        to_verdict();
        exp_score = model_score(exp_score, 1'b1);
        checks++;
        if (RESULT !== 2'b11 || PRODUCT !== 10'd729 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL max_ok got R=%b P=%0d S=%0d want R=11 P=729 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        to_idle();
        pulse(9, 9, 8, 729);
        to_verdict();
        checks++;
        if (RESULT !== 2'b01 || PRODUCT !== 10'd648 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL max_wrong got R=%b P=%0d S=%0d want R=01 P=648 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        to_idle();
    endtask

    task automatic test_zero();
        pulse(2, 3, 0, 0);
        to_verdict();
        checks++;
        if (RESULT !== 2'b01 || PRODUCT !== 10'd0 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL zero_digit got R=%b P=%0d S=%0d want R=01 P=0 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        to_idle();
    endtask

    task automatic test_repulse();
        pulse(4, 5, 6, 120);
        D1 = 4'd1; D2 = 4'd1; D3 = 4'd1; TARGET = 10'd1;
        repeat (2) @(negedge CLK);
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        repeat (6) @(negedge CLK);
        exp_score = model_score(exp_score, 1'b1);
        checks++;
        if (RESULT !== 2'b11 || PRODUCT !== 10'd120 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL repulse_verdict got R=%b P=%0d S=%0d want R=11 P=120 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        D1 = 4'd2; D2 = 4'd2; D3 = 4'd2; TARGET = 10'd8;
        VALID = 1'b1;
        @(negedge CLK);
        VALID = 1'b0;
        repeat (HOLD - 1) @(negedge CLK);
        repeat (3) @(negedge CLK);
        checks++;
        if (RESULT !== 2'b00 || BUSY !== 1'b0 || PRODUCT !== 10'd120) begin
            errors++;
            $display("FAIL repulse_idle got R=%b B=%b P=%0d want R=00 B=0 P=120", RESULT, BUSY, PRODUCT);
        end
    endtask

    task automatic test_held();
        D1 = 4'd1; D2 = 4'd2; D3 = 4'd3; TARGET = 10'd6;
        VALID = 1'b1;
        repeat (3) @(negedge CLK);
        VALID = 1'b0;
        repeat (7) @(negedge CLK);
        exp_score = model_score(exp_score, 1'b1);
        checks++;
        if (RESULT !== 2'b11 || PRODUCT !== 10'd6 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL held_verdict got R=%b P=%0d S=%0d want R=11 P=6 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        to_idle();
        repeat (3) @(negedge CLK);
        checks++;
        if (RESULT !== 2'b00 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL held_single got R=%b B=%b want R=00 B=0", RESULT, BUSY);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int a, b, c, t;
            bit ok;
            a = int'($urandom_range(0, 9));
            b = int'($urandom_range(0, 9));
            c = int'($urandom_range(0, 9));
            t = ($urandom_range(0, 1) == 1) ? a * b * c : int'($urandom_range(0, 729));
            ok = model_correct(a, b, c, t);
            pulse(a, b, c, t);
            D1 = 4'($urandom); D2 = 4'($urandom); D3 = 4'($urandom); TARGET = 10'($urandom);
            to_verdict();
            exp_score = model_score(exp_score, ok);
            checks++;
            if (RESULT !== {ok, 1'b1} || PRODUCT !== 10'(a * b * c) || SCORE !== 4'(exp_score)) begin
                errors++;
                $display("FAIL random%0d d=%0d,%0d,%0d t=%0d got R=%b P=%0d S=%0d want R=%b P=%0d S=%0d",
                         n, a, b, c, t, RESULT, PRODUCT, SCORE, {ok, 1'b1}, a * b * c, exp_score);
            end
            to_idle();
            checks++;
            if (RESULT !== 2'b00 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL random_idle%0d got R=%b B=%b want R=00 B=0", n, RESULT, BUSY);
            end
        end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 10; n++) begin
            int a, b, c;
            a = int'($urandom_range(1, 9));
            b = int'($urandom_range(1, 9));
            c = int'($urandom_range(1, 9));
            pulse(a, b, c, a * b * c);
            to_verdict();
            exp_score = model_score(exp_score, 1'b1);
            checks++;
            if (RESULT !== 2'b11 || SCORE !== 4'(exp_score)) begin
                errors++;
                $display("FAIL saturate%0d got R=%b S=%0d want R=11 S=%0d", n, RESULT, SCORE, exp_score);
            end
            to_idle();
        end
        checks++;
        if (SCORE !== 4'd9) begin
            errors++;
            $display("FAIL saturate_final got S=%0d want 9", SCORE);
        end
    endtask

    task automatic test_reset_mid();
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        exp_score = 0;
        @(negedge CLK);
        pulse(4, 4, 4, 64);
        repeat (5) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({RESULT, PRODUCT, SCORE, BUSY} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid got R=%b P=%0d S=%0d B=%b want all zero", RESULT, PRODUCT, SCORE, BUSY);
        end
        @(negedge CLK);
        RST = 1'b1;
        repeat (12) @(negedge CLK);
        checks++;
        if (SCORE !== 4'd0 || RESULT !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_after got R=%b S=%0d want R=00 S=0", RESULT, SCORE);
        end
        pulse(3, 3, 3, 27);
        to_verdict();
        exp_score = model_score(exp_score, 1'b1);
        checks++;
        if (RESULT !== 2'b11 || PRODUCT !== 10'd27 || SCORE !== 4'(exp_score)) begin
            errors++;
            $display("FAIL reset_mid_round got R=%b P=%0d S=%0d want R=11 P=27 S=%0d", RESULT, PRODUCT, SCORE, exp_score);
        end
        to_idle();
    endtask

    initial begin
        test_reset();
        test_correct();
        test_max();
        test_zero();
        test_repulse();
        test_held();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
